sintetizador_sequenciador: RTL

Autonomous note sequencer for the audio synthesizer. It reads a song from SRAM over the read-only synthesizer bus (`wReadEnableS` / `wAddressS` / `wReadDataS`) and replays each event on the synthesizer note controls. Events are paced in audio sample ticks taken from `AUD_DACLRCK`. The CPU configures and starts it through memory-mapped registers on the IO bus, and sits alongside the synthesizer's existing note registers.

---
 rtl/sintetizador_sequenciador.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sintetizador_sequenciador.sv
// Song sequencer: fetches event words from SRAM and replays them on the synth note port, paced by LRCK ticks.
// Start to first read is 1 cycle; a note strobes READ_LATENCY+1 cycles after its read; the synth bus is never stalled.
module sintetizador_sequenciador #(
    parameter logic [31:0] SEQ_BASE_ADDRESS   = 32'hFFFF0140,
    parameter logic [31:0] SEQ_COUNT_ADDRESS  = 32'hFFFF0144,
    parameter logic [31:0] SEQ_CTRL_ADDRESS   = 32'hFFFF0148,
    parameter logic [31:0] SEQ_STATUS_ADDRESS = 32'hFFFF014C,
    parameter int          READ_LATENCY       = 2
) (
    input  logic        iCLK,
    input  logic        Reset,
    input  logic        AUD_DACLRCK,
    input  logic        wReadEnable,
    input  logic        wWriteEnable,
    input  logic [3:0]  wByteEnable,
    input  logic [31:0] wAddress,
    input  logic [31:0] wWriteData,
    output logic [31:0] wReadData,
    output logic        wReadEnableS,
    output logic [31:0] wAddressS,
    input  logic [31:0] wReadDataS,
    output logic [7:0]  oNote,
    output logic        oNoteStrobe,
    output logic        oBusy
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_APPLY, S_DELAY} state_t;

    state_t      state;
    logic [29:0] baseReg;
    logic [15:0] countReg;
    logic        loopEn;
    logic [29:0] runBase;
    logic [15:0] runCount;
    logic [15:0] index;
    logic [31:0] eventWord;
    logic [23:0] delayCnt;
    logic [7:0]  waitCnt;
    logic [2:0]  lrcSync;

    logic        tick;
    logic        ctrlWrite;
    logic        startCmd;
    logic        stopCmd;
    logic        isMarker;
    logic        lastEvent;
    logic        songDone;
    logic [15:0] nextIndex;
    logic        unusedByteEnable;

    assign unusedByteEnable = &{1'b0, wByteEnable};

    // [1:0] synchronize the async LR clock, [2] is the previous synchronized value for edge detection.
    always_ff @(posedge iCLK or negedge Reset) begin
        if (!Reset) lrcSync <= 3'b000;
        else        lrcSync <= {lrcSync[1:0], AUD_DACLRCK};
    end
    assign tick = lrcSync[1] & ~lrcSync[2];

    assign ctrlWrite = wWriteEnable && (wAddress == SEQ_CTRL_ADDRESS);
    assign stopCmd   = ctrlWrite && wWriteData[2];
    assign startCmd  = ctrlWrite && wWriteData[0] && !wWriteData[2];

    always_ff @(posedge iCLK or negedge Reset) begin
        if (!Reset) begin
            baseReg  <= '0;
            countReg <= '0;
            loopEn   <= 1'b0;
        end else if (wWriteEnable) begin
            if (wAddress == SEQ_BASE_ADDRESS)  baseReg  <= wWriteData[31:2];
            if (wAddress == SEQ_COUNT_ADDRESS) countReg <= wWriteData[15:0];
            if (wAddress == SEQ_CTRL_ADDRESS)  loopEn   <= wWriteData[1];
        end
    end

    assign wReadData = (wReadEnable && (wAddress == SEQ_STATUS_ADDRESS))
                     ? {15'b0, oBusy, index} : 32'hzzzzzzzz;

    assign isMarker  = (eventWord == 32'hFFFF_FFFF);
    assign lastEvent = (({1'b0, index} + 17'd1) == {1'b0, runCount}) || isMarker;
    assign nextIndex = lastEvent ? 16'd0 : index + 16'd1;
    assign songDone  = lastEvent && !loopEn;

    function automatic logic [31:0] fetchAddr(input logic [29:0] base, input logic [15:0] idx);
        return {base, 2'b00} + {14'd0, idx, 2'b00};
    endfunction

    always_ff @(posedge iCLK or negedge Reset) begin
        if (!Reset) begin
            state        <= S_IDLE;
            runBase      <= '0;
            runCount     <= '0;
            index        <= '0;
            eventWord    <= '0;
            delayCnt     <= '0;
            waitCnt      <= '0;
            oNote        <= 8'h00;
            oNoteStrobe  <= 1'b0;
            oBusy        <= 1'b0;
            wReadEnableS <= 1'b0;
            wAddressS    <= '0;
        end else begin
            oNoteStrobe  <= 1'b0;
            wReadEnableS <= 1'b0;
            if (stopCmd && state != S_IDLE) begin
                // Release the held note; any outstanding read is simply never sampled.
                state       <= S_IDLE;
                oBusy       <= 1'b0;
                oNote       <= 8'h00;
                oNoteStrobe <= 1'b1;
            end else if (startCmd && countReg != 16'd0) begin
                runBase      <= baseReg;
                runCount     <= countReg;
                index        <= 16'd0;
                state        <= S_FETCH;
                oBusy        <= 1'b1;
                wReadEnableS <= 1'b1;
                wAddressS    <= fetchAddr(baseReg, 16'd0);
            end else begin
                case (state)
                    S_IDLE: ;
                    S_FETCH: begin
                        waitCnt <= 8'(READ_LATENCY - 1);
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (waitCnt == 8'd0) begin
                            eventWord <= wReadDataS;
                            delayCnt  <= wReadDataS[31:8];
                            state     <= S_APPLY;
                            // Note goes out as APPLY is entered so the strobe coincides with the APPLY cycle.
                            if (wReadDataS != 32'hFFFF_FFFF) begin
                                oNote       <= wReadDataS[7:0];
                                oNoteStrobe <= 1'b1;
                            end
                        end else begin
                            waitCnt <= waitCnt - 8'd1;
                        end
                    end
                    S_APPLY: begin
                        if (isMarker || delayCnt == 24'd0) begin
                            if (songDone) begin
                                state <= S_IDLE;
                                oBusy <= 1'b0;
                            end else begin
                                index        <= nextIndex;
                                state        <= S_FETCH;
                                wReadEnableS <= 1'b1;
                                wAddressS    <= fetchAddr(runBase, nextIndex);
                            end
                        end else begin
                            state <= S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        // Advancing on the final tick itself puts FETCH one cycle after that tick.
                        if (delayCnt == 24'd0 || (tick && delayCnt == 24'd1)) begin
                            if (songDone) begin
                                state <= S_IDLE;
                                oBusy <= 1'b0;
                            end else begin
                                index        <= nextIndex;
                                state        <= S_FETCH;
                                wReadEnableS <= 1'b1;
                                wAddressS    <= fetchAddr(runBase, nextIndex);
                            end
                        end else if (tick) begin
                            delayCnt <= delayCnt - 24'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        oBusy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
